// File: rtl/multi_tick_gen.sv
// N-channel tick/strobe generator: per-channel run-time period, periodic or one-shot mode,
// glitch-free period updates through a shadow register, shared phase-align restart, divided clock.
module multi_tick_gen #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 22,
  parameter int DEFAULT_PERIOD = 833332,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_oneshot,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } ch_state_t;

  ch_state_t        state_q [NUM_CH];
  ch_state_t        state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [CNT_W-1:0] period_q [NUM_CH];
  logic [CNT_W-1:0] period_d [NUM_CH];
  logic [CNT_W-1:0] shadow_period_q [NUM_CH];
  logic [CNT_W-1:0] shadow_period_d [NUM_CH];

  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] shadow_mode_q, shadow_mode_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] div_q, div_d;
  logic [NUM_CH-1:0] apply;

  logic rst_sync_q;

  // Reset assertion is immediate; release is held off one edge so the channels first move
  // on the second clk_50 edge after rst_n rises.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= 1'b1;
    end
  end

  // Out-of-range channel numbers report ready and their writes fall through unmatched.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pending_q[i];
      end
    end
  end

  always_comb begin
    tick_d = '0;
    div_d = div_q;
    mode_d = mode_q;
    shadow_mode_d = shadow_mode_q;
    pending_d = pending_q;
    apply = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i] = cnt_q[i];
      period_d[i] = period_q[i];
      shadow_period_d[i] = shadow_period_q[i];

      if (!ch_en[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i] = '0;
        div_d[i] = 1'b0;
        apply[i] = pending_q[i] && (state_q[i] != ST_RUN);
      end else if (sync_restart) begin
        state_d[i] = ST_RUN;
        cnt_d[i] = '0;
        apply[i] = pending_q[i];
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            state_d[i] = ST_RUN;
            cnt_d[i] = '0;
            apply[i] = pending_q[i];
          end
          ST_RUN: begin
            if (cnt_q[i] == period_q[i]) begin
              cnt_d[i] = '0;
              tick_d[i] = 1'b1;
              div_d[i] = ~div_q[i];
              apply[i] = pending_q[i];
              if (mode_q[i]) begin
                state_d[i] = ST_DONE;
              end
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          ST_DONE: begin
            apply[i] = pending_q[i];
          end
          default: begin
            state_d[i] = ST_IDLE;
          end
        endcase
      end

      // Period and mode only ever change together at a wrap or restart boundary.
      if (apply[i]) begin
        period_d[i] = shadow_period_q[i];
        mode_d[i] = shadow_mode_q[i];
        pending_d[i] = 1'b0;
      end

      if (cfg_valid && (cfg_ch == CH_W'(i)) && !pending_q[i]) begin
        shadow_period_d[i] = cfg_period;
        shadow_mode_d[i] = cfg_oneshot;
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i] <= '0;
        period_q[i] <= CNT_W'(DEFAULT_PERIOD);
        shadow_period_q[i] <= CNT_W'(DEFAULT_PERIOD);
      end
      mode_q <= '0;
      shadow_mode_q <= '0;
      pending_q <= '0;
      tick_q <= '0;
      div_q <= '0;
    end else if (rst_sync_q) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i] <= cnt_d[i];
        period_q[i] <= period_d[i];
        shadow_period_q[i] <= shadow_period_d[i];
      end
      mode_q <= mode_d;
      shadow_mode_q <= shadow_mode_d;
      pending_q <= pending_d;
      tick_q <= tick_d;
      div_q <= div_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (state_q[i] == ST_RUN);
    end
  end

  assign tick = tick_q;
  assign div_clk = div_q;

endmodule
